bsg_cache_sbuf_drain: RTL

Downstream consumer of the cache store buffer. Pops committed store entries and holds each one in a single write register. Issues the entry as a masked write to the way-interleaved data memory, yielding to pipeline data-memory reads. A bounded starvation counter guarantees forward progress, and a flush sequence drains all pending stores before a miss or flush operation proceeds.

---
 rtl/bsg_cache_pkg.sv | 30 +++
 rtl/bsg_cache_sbuf_drain_expand.sv | 25 ++
 rtl/bsg_cache_sbuf_drain.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared types for the cache store-buffer drain path: entry layout and drain FSM states.
// Entry fields are packed MSB-first as {addr, data, mask, way_id}.
package bsg_cache_pkg;

    localparam int default_addr_width_lp = 28;
    localparam int default_data_width_lp = 32;
    localparam int default_ways_lp       = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

    function automatic int bsg_cache_lg_ways(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int bsg_cache_sbuf_entry_width(input int addr_w, input int data_w, input int ways);
        return addr_w + data_w + (data_w / 8) + bsg_cache_lg_ways(ways);
    endfunction

    typedef struct packed {
        logic [default_addr_width_lp-1:0]       addr;
        logic [default_data_width_lp-1:0]       data;
        logic [default_data_width_lp/8-1:0]     mask;
        logic [$clog2(default_ways_lp)-1:0]     way_id;
    } bsg_cache_sbuf_entry_s;

endpackage

// File: rtl/bsg_cache_sbuf_drain_expand.sv
// Maps one store {data, mask, way_id} onto the way-interleaved data memory word.
// Combinational, no latency; no flow control of its own.
module bsg_cache_sbuf_drain_expand
    import bsg_cache_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int ways_p       = 2,
    localparam int data_mask_width_lp = data_width_p / 8,
    localparam int lg_ways_lp         = bsg_cache_lg_ways(ways_p)
) (
    input  logic [data_width_p-1:0]               data_i,
    input  logic [data_mask_width_lp-1:0]         mask_i,
    input  logic [lg_ways_lp-1:0]                 way_id_i,
    output logic [ways_p*data_width_p-1:0]        data_o,
    output logic [ways_p*data_mask_width_lp-1:0]  w_mask_o
);

    assign data_o = {ways_p{data_i}};

    for (genvar w = 0; w < ways_p; w++) begin : g_way
        assign w_mask_o[w*data_mask_width_lp +: data_mask_width_lp] =
            (way_id_i == lg_ways_lp'(w)) ? mask_i : '0;
    end

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// Pops store-buffer entries into one write register and writes them to data memory, yielding to reads.
// Pop-to-write 1 cycle; reads defer the write up to starve_limit_p cycles, flush forces all writes through.
module bsg_cache_sbuf_drain
    import bsg_cache_pkg::*;
#(
    parameter int addr_width_p          = 28,
    parameter int data_width_p          = 32,
    parameter int ways_p                = 2,
    parameter int sets_p                = 64,
    parameter int block_size_in_words_p = 8,
    parameter int starve_limit_p        = 4,
    localparam int data_mask_width_lp   = data_width_p / 8,
    localparam int lg_ways_lp           = bsg_cache_lg_ways(ways_p),
    localparam int entry_width_lp       = bsg_cache_sbuf_entry_width(addr_width_p, data_width_p, ways_p),
    localparam int dmem_addr_width_lp   = $clog2(sets_p * block_size_in_words_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic [entry_width_lp-1:0]             sbuf_entry_i,
    input  logic                                  sbuf_v_i,
    output logic                                  sbuf_yumi_o,
    input  logic                                  sbuf_empty_i,
    input  logic                                  dmem_read_req_i,
    output logic                                  dmem_stall_o,
    output logic                                  dmem_v_o,
    output logic                                  dmem_w_o,
    output logic [dmem_addr_width_lp-1:0]         dmem_addr_o,
    output logic [ways_p*data_width_p-1:0]        dmem_data_o,
    output logic [ways_p*data_mask_width_lp-1:0]  dmem_w_mask_o,
    input  logic                                  flush_i,
    output logic                                  flush_done_o
);

    localparam int byte_off_width_lp = $clog2(data_mask_width_lp);
    localparam int cnt_width_lp      = $clog2(starve_limit_p + 1);

    typedef struct packed {
        logic [addr_width_p-1:0]       addr;
        logic [data_width_p-1:0]       data;
        logic [data_mask_width_lp-1:0] mask;
        logic [lg_ways_lp-1:0]         way_id;
    } sbuf_entry_s;

    sbuf_entry_s             w_entry;
    sbuf_entry_s             r_entry;
    logic                    r_wr_v;
    logic                    r_reset_d;
    logic [cnt_width_lp-1:0] r_starve_cnt;
    logic [cnt_width_lp-1:0] w_starve_cnt_nxt;
    drain_state_e            r_state;
    drain_state_e            w_state_nxt;
    logic                    w_en;
    logic                    w_force;
    logic                    w_issue;
    logic                    w_yumi;
    logic                    w_unused_addr;

    assign w_entry = sbuf_entry_i;

    // Outputs stay quiet during reset and the cycle after it.
    assign w_en    = ~reset_i & ~r_reset_d;
    assign w_force = (r_starve_cnt == cnt_width_lp'(starve_limit_p)) | (r_state == DRAIN);
    assign w_issue = w_en & r_wr_v & (~dmem_read_req_i | w_force);
    assign w_yumi  = w_en & sbuf_v_i & (~r_wr_v | w_issue);

    assign sbuf_yumi_o  = w_yumi;
    assign dmem_v_o     = w_issue;
    assign dmem_w_o     = w_issue;
    assign dmem_stall_o = dmem_read_req_i & w_issue;
    assign dmem_addr_o  = r_entry.addr[byte_off_width_lp +: dmem_addr_width_lp];
    assign w_unused_addr = ^r_entry.addr;

    bsg_cache_sbuf_drain_expand #(
        .data_width_p (data_width_p),
        .ways_p       (ways_p)
    ) u_expand (
        .data_i   (r_entry.data),
        .mask_i   (r_entry.mask),
        .way_id_i (r_entry.way_id),
        .data_o   (dmem_data_o),
        .w_mask_o (dmem_w_mask_o)
    );

    always_comb begin
        w_starve_cnt_nxt = r_starve_cnt;
        if (~r_wr_v | w_issue) begin
            w_starve_cnt_nxt = '0;
        end else if (dmem_read_req_i && (r_starve_cnt != cnt_width_lp'(starve_limit_p))) begin
            w_starve_cnt_nxt = r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        r_reset_d <= reset_i;
        if (reset_i) begin
            r_wr_v       <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            r_wr_v       <= w_yumi | (r_wr_v & ~w_issue);
            r_starve_cnt <= w_starve_cnt_nxt;
        end
    end

    // Entry payload needs no reset; r_wr_v qualifies it.
    always_ff @(posedge clk_i) begin
        if (w_yumi) begin
            r_entry <= w_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        flush_done_o = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_en & flush_i) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (sbuf_empty_i & ~sbuf_v_i & ~r_wr_v) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                flush_done_o = w_en;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
